comparator_bist: RTL

//  Self-test harness for the n-bit `comparator`: it is the driving end of that block's interface.
//  - On `start`, generates NUM_VECTORS pseudo-random {A,B,C} triples from an LFSR.
//  - Applies each triple, samples OUT1/OUT2, and compacts the responses into a MISR signature.
//  - Flags pass/fail against a golden signature. Sits beside the comparator on-chip and replaces

---
 rtl/comparator_bist_pkg.sv | 11 +
 rtl/comparator_bist_if.sv | 9 +
 rtl/bist_lfsr.sv | 25 ++
 rtl/comparator_bist.sv | 73 +++++++
 4 files changed

// File: rtl/comparator_bist_pkg.sv
// comparator_bist_pkg: shared FSM state encoding and default polynomial masks for the n=5 harness.
package comparator_bist_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;
    localparam logic [14:0] LFSR_TAPS_N5 = 15'h6000;
    localparam logic [9:0]  MISR_TAPS_N5 = 10'h240;
endpackage

// File: rtl/comparator_bist_if.sv
// comparator_bist_if: operand/response bundle between the BIST (master) and the comparator (slave).
//   A, B, C      n-bit operands driven by the master
//   OUT1, OUT2   2n-bit responses driven by the slave
interface comparator_bist_if #(parameter int n = 5);
    logic [n-1:0]   A, B, C;
    logic [2*n-1:0] OUT1, OUT2;
    modport master(output A, B, C, input OUT1, OUT2);
    modport slave(input A, B, C, output OUT1, OUT2);
endinterface

// File: rtl/bist_lfsr.sv
// bist_lfsr: Fibonacci LFSR stimulus generator.
//   clk, rst   clock, synchronous active-high reset (clears q)
//   load       load SEED (an all-zero SEED is replaced by 1 so the LFSR never locks up)
//   step       shift in the feedback bit
//   q          current LFSR contents
module bist_lfsr #(
    parameter int               WIDTH = 15,
    parameter logic [WIDTH-1:0] TAPS  = '1,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= SEED == '0 ? WIDTH'(1) : SEED;
        else if (step)
            q <= {q[WIDTH-2:0], ^(q & TAPS)};
    end
endmodule

// File: rtl/comparator_bist.sv
// comparator_bist: LFSR-driven self-test of the comparator with MISR response compaction.
//   clk, rst    clock, synchronous active-high reset (aborts any run)
//   start       begin a run; honoured only in IDLE or DONE
//   cmp         master side of the comparator bus (A/B/C out, OUT1/OUT2 in)
//   busy        run in progress
//   done        run finished, signature stable
//   pass        done and signature matches GOLDEN
//   signature   MISR contents
module comparator_bist
    import comparator_bist_pkg::*;
#(
    parameter int               n           = 5,
    parameter int               NUM_VECTORS = 20,
    parameter logic [3*n-1:0]   SEED        = 15'h0001,
    parameter logic [3*n-1:0]   LFSR_TAPS   = LFSR_TAPS_N5,
    parameter logic [2*n-1:0]   MISR_TAPS   = MISR_TAPS_N5,
    parameter logic [2*n-1:0]   GOLDEN      = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    comparator_bist_if.master    cmp,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*n-1:0]       signature
);
    localparam int CW = $clog2(NUM_VECTORS + 1);
    state_t         state, next;
    logic [2*n-1:0] misr;
    logic [CW-1:0]  count;
    logic [3*n-1:0] lfsr;
    logic           load, step, last;
    assign load = start && (state == IDLE || state == DONE);
    assign step = state == CAPTURE;
    assign last = count == CW'(NUM_VECTORS - 1);
    bist_lfsr #(.WIDTH(3*n), .TAPS(LFSR_TAPS), .SEED(SEED)) u_lfsr (
        .clk(clk), .rst(rst), .load(load), .step(step), .q(lfsr)
    );
    assign cmp.A = lfsr[n-1:0];
    assign cmp.B = lfsr[2*n-1:n];
    assign cmp.C = lfsr[3*n-1:2*n];
    assign signature = misr;
    always_comb begin
        next = state;
        busy = state == APPLY || state == CAPTURE;
        done = state == DONE;
        pass = done && misr == GOLDEN;
        if (load)
            next = APPLY;
        else if (state == APPLY)
            next = CAPTURE;
        else if (state == CAPTURE)
            next = last ? DONE : APPLY;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            misr  <= '0;
            count <= '0;
        end else begin
            state <= next;
            if (load) begin
                misr  <= '0;
                count <= '0;
            end else if (step) begin
                // OUT2 enters rotated right by one so equal OUT1/OUT2 words do not cancel
                misr  <= {misr[2*n-2:0], ^(misr & MISR_TAPS)} ^ cmp.OUT1 ^ {cmp.OUT2[0], cmp.OUT2[2*n-1:1]};
                count <= count + CW'(1);
            end
        end
    end
endmodule
